// File: rtl/frame_column_writer_if.sv
// Configuration word stream between the bitstream source and one column writer.
// Latency: none (plain wires); a word transfers on a cycle with cfg_valid and cfg_ready both high.
// Backpressure: the writer drops cfg_ready while it strobes a frame; the source must hold its word.
// Signals:
//   cfg_data  - 32-bit configuration word (header or frame data row)
//   cfg_valid - source has a word on cfg_data
//   cfg_ready - writer accepts the word this cycle
interface frame_column_writer_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  // Word source side.
  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  // Column writer side.
  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/frame_column_writer.sv
// Column configuration driver: assembles NumRows config words into FrameData, then pulses one FrameStrobe bit.
// Latency: FrameStrobe rises on the edge that accepts the last row word, stays high StrobeWidth cycles, then one hold cycle.
// Backpressure: cfg_ready is high in IDLE/LOAD/SKIP and low during STROBE and HOLD; cfg_valid low simply stalls.
// Ports:
//   CLK, resetn  - configuration clock, asynchronous active-low reset
//   cfg_if       - config word stream (slave side: cfg_data, cfg_valid in; cfg_ready out)
//   FrameData    - registered frame data, row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe  - registered one-hot frame write strobe
//   busy         - high whenever the writer is not in IDLE
//   err_opcode   - sticky: a header carried an opcode other than 0xA5
//   err_frame    - sticky: a header carried a frame index >= MaxFramesPerCol
//   err_clr      - synchronous clear of both error flags (wins over a same-cycle set)
module frame_column_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int ColIndex        = 0,
  parameter int StrobeWidth     = 2
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  frame_column_writer_if.slave                 cfg_if,
  output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 err_opcode,
  output logic                                 err_frame,
  input  logic                                 err_clr
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SKIP   = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  localparam logic [7:0] OP_WRITE_FRAME = 8'hA5;

  // Row counter is at least one bit wide so a single-row column still elaborates.
  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LAST_ROW = RowW'(NumRows - 1);

  // StrobeWidth is limited to 1..15, so four bits always suffice.
  localparam logic [3:0] STROBE_LAST = 4'(StrobeWidth - 1);

  localparam int DataW = FrameBitsPerRow * NumRows;

  // State registers
  logic [2:0]                 state_q,  state_d;
  logic [RowW-1:0]            row_q,    row_d;
  logic [4:0]                 frame_q,  frame_d;
  logic [3:0]                 scnt_q,   scnt_d;
  logic [DataW-1:0]           data_q,   data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       err_op_q, err_op_d;
  logic                       err_fr_q, err_fr_d;

  // Header fields
  logic [7:0] hdr_opcode;
  logic [4:0] hdr_column;
  logic [4:0] hdr_frame;
  logic       hdr_frame_bad;
  logic       hdr_col_other;

  logic                       cfg_ready;
  logic                       accept;
  logic                       set_err_op;
  logic                       set_err_fr;
  logic [MaxFramesPerCol-1:0] frame_onehot;

  assign hdr_opcode    = cfg_if.cfg_data[31:24];
  assign hdr_column    = cfg_if.cfg_data[12:8];
  assign hdr_frame     = cfg_if.cfg_data[4:0];
  assign hdr_frame_bad = ({27'd0, hdr_frame} >= 32'(MaxFramesPerCol));
  assign hdr_col_other = (hdr_column != 5'(ColIndex));

  // The writer only listens while collecting headers or row words.
  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_SKIP);
  assign accept    = cfg_if.cfg_valid && cfg_ready;

  // Decode of the latched frame index; only consulted once the header passed the range check.
  always_comb begin
    frame_onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      frame_onehot[i] = (frame_q == 5'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    frame_d    = frame_q;
    scnt_d     = scnt_q;
    data_d     = data_q;
    strobe_d   = strobe_q;
    set_err_op = 1'b0;
    set_err_fr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_opcode != OP_WRITE_FRAME) begin
            // Bad opcode: no data words follow, so the word is simply dropped.
            set_err_op = 1'b1;
          end else if (hdr_frame_bad) begin
            set_err_fr = 1'b1;
            row_d      = '0;
            state_d    = ST_SKIP;
          end else if (hdr_col_other) begin
            // Frame for another column: consume its rows silently.
            row_d   = '0;
            state_d = ST_SKIP;
          end else begin
            frame_d = hdr_frame;
            row_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_q == RowW'(r)) begin
              data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = cfg_if.cfg_data[FrameBitsPerRow-1:0];
            end
          end
          if (row_q == LAST_ROW) begin
            // Strobe is registered on the same edge as the last row, so it
            // appears the cycle right after that word was presented.
            strobe_d = frame_onehot;
            scnt_d   = '0;
            state_d  = ST_STROBE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      ST_SKIP: begin
        if (accept) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      ST_STROBE: begin
        if (scnt_q == STROBE_LAST) begin
          strobe_d = '0;
          state_d  = ST_HOLD;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        // One idle cycle keeps FrameData stable after the strobe falls.
        state_d = ST_IDLE;
      end

      default: begin
        strobe_d = '0;
        state_d  = ST_IDLE;
      end
    endcase

    // Clear beats a same-cycle set.
    err_op_d = err_clr ? 1'b0 : (err_op_q | set_err_op);
    err_fr_d = err_clr ? 1'b0 : (err_fr_q | set_err_fr);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      frame_q  <= '0;
      scnt_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      err_op_q <= 1'b0;
      err_fr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      frame_q  <= frame_d;
      scnt_q   <= scnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      err_op_q <= err_op_d;
      err_fr_q <= err_fr_d;
    end
  end

  assign cfg_if.cfg_ready = cfg_ready;
  assign FrameData        = data_q;
  assign FrameStrobe      = strobe_q;
  assign busy             = (state_q != ST_IDLE);
  assign err_opcode       = err_op_q;
  assign err_frame        = err_fr_q;

endmodule

// File: tb/tb_frame_column_writer.sv
// Bench for frame_column_writer: directed scenarios plus randomized headers/data against a frame-level model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_frame_column_writer;
  localparam int SW    = 2;
  localparam int NFR   = 20;
  localparam int NROW  = 4;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         err_clr;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy;
  logic         err_opcode;
  logic         err_frame;

  frame_column_writer_if cfg_bus();

  frame_column_writer #(
    .MaxFramesPerCol (NFR),
    .FrameBitsPerRow (32),
    .NumRows         (NROW),
    .ColIndex        (0),
    .StrobeWidth     (SW)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .cfg_if      (cfg_bus),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err_opcode  (err_opcode),
    .err_frame   (err_frame),
    .err_clr     (err_clr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Frame-level model: current column contents and expected sticky flags.
  logic [31:0] exp_data [NROW];
  logic        exp_err_op;
  logic        exp_err_fr;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    for (int r = 0; r < NROW; r++) v[r*32 +: 32] = exp_data[r];
    return v;
  endfunction

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Presents one word (after 'gap' idle cycles) and returns on the falling
  // edge right after the clock edge that took it.
  task automatic put_word(input logic [31:0] w, input int gap);
    int n;
    cfg_bus.cfg_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    cfg_bus.cfg_data  = w;
    cfg_bus.cfg_valid = 1'b1;
    n = 0;
    while (!cfg_bus.cfg_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(negedge CLK);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Sends a header and, when one is implied, its NROW data words; checks the
  // outcome right after the last word. mode: 0 no gaps, 1 toggled valid, 2 random gaps.
  task automatic do_frame(input logic [31:0] hdr, input logic [127:0] words, input int mode);
    logic [4:0] fidx;
    bit         wr;
    fidx = hdr[4:0];
    put_word(hdr, pick_gap(mode));
    if (hdr[31:24] != 8'hA5) begin
      exp_err_op = 1'b1;
      chk("err_opcode", err_opcode, exp_err_op);
      chk("busy_bad_op", busy, 0);
      return;
    end
    if (fidx >= NFR) exp_err_fr = 1'b1;
    wr = (fidx < NFR) && (hdr[12:8] == 5'd0);
    chk("err_frame", err_frame, exp_err_fr);
    chk("busy_after_hdr", busy, 1);
    for (int r = 0; r < NROW; r++) begin
      put_word(words[r*32 +: 32], pick_gap(mode));
      if (wr) exp_data[r] = words[r*32 +: 32];
      if (r < NROW - 1) chk("strobe_in_load", FrameStrobe, 0);
    end
    chk("frame_data", FrameData, exp_vec());
    if (wr) begin
      chk("strobe_index", FrameStrobe, 20'd1 << fidx);
      chk("ready_in_strobe", cfg_bus.cfg_ready, 0);
    end else begin
      chk("strobe_skip", FrameStrobe, 0);
      chk("busy_after_skip", busy, 0);
    end
  endtask

  // Pulse-shape monitor: one-hot, width SW, spacing, and ready-low run of SW+1.
  int run = 0;
  int rdy_low = 0;
  int since_fall = 100;
  always @(negedge CLK) begin
    if (!resetn) begin
      run = 0;
      rdy_low = 0;
    end else begin
      if (FrameStrobe != '0) begin
        if (run == 0) chk("strobe_gap", since_fall >= 2, 1);
        chk("strobe_onehot", $countones(FrameStrobe), 1);
        run++;
      end else begin
        if (run != 0) begin
          chk("strobe_width", run, SW);
          run = 0;
          since_fall = 0;
        end
        since_fall++;
      end
      if (!cfg_bus.cfg_ready) rdy_low++;
      else if (rdy_low != 0) begin
        chk("ready_low_len", rdy_low, SW + 1);
        rdy_low = 0;
      end
    end
  end

  initial begin
    logic [31:0]  hdr;
    logic [127:0] wv;
    int           cnt;

    resetn            = 1'b0;
    err_clr           = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = '0;
    exp_err_op        = 1'b0;
    exp_err_fr        = 1'b0;
    for (int r = 0; r < NROW; r++) exp_data[r] = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_data", FrameData, 0);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_err_op", err_opcode, 0);
    chk("rst_err_fr", err_frame, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge CLK);
    chk("rst_ready", cfg_bus.cfg_ready, 1);

    // Basic write to frame 3
    do_frame(32'hA500_0003, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0);
    chk("frame3_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    chk("frame3_strobe", FrameStrobe, 20'h00008);

    // Other column: words consumed, nothing written
    do_frame(32'hA500_0105, {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001}, 0);
    chk("skip_err_op", err_opcode, 0);
    chk("skip_err_fr", err_frame, 0);

    // Bad opcode, then out-of-range frame, then clear
    do_frame(32'h3C00_0000, '0, 0);
    do_frame(32'hA500_0014, {32'hBAD0_0004, 32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001}, 0);
    chk("both_err_op", err_opcode, 1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    exp_err_op = 1'b0;
    exp_err_fr = 1'b0;
    chk("clr_err_op", err_opcode, exp_err_op);
    chk("clr_err_fr", err_frame, exp_err_fr);

    // Clear wins over a same-cycle bad-opcode set
    err_clr = 1'b1;
    put_word(32'h1200_0000, 0);
    err_clr = 1'b0;
    chk("clr_priority", err_opcode, 0);
    chk("clr_priority_busy", busy, 0);

    // Frame 19 with cfg_valid toggling every cycle
    do_frame(32'hA500_0013, {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001}, 1);
    chk("frame19_strobe", FrameStrobe, 20'h80000);

    // Back-to-back frames 0 and 1
    do_frame(32'hA500_0000, {32'hA0A0_0004, 32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001}, 0);
    do_frame(32'hA500_0001, {32'hB1B1_0004, 32'hB1B1_0003, 32'hB1B1_0002, 32'hB1B1_0001}, 0);

    // Reset in the first STROBE cycle
    do_frame(32'hA500_0002, {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001}, 0);
    resetn = 1'b0;
    #1;
    chk("midrst_strobe", FrameStrobe, 0);
    chk("midrst_data", FrameData, 0);
    for (int r = 0; r < NROW; r++) exp_data[r] = '0;
    exp_err_op = 1'b0;
    exp_err_fr = 1'b0;
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("postrst_busy", busy, 0);
    chk("postrst_ready", cfg_bus.cfg_ready, 1);
    cnt = 0;
    repeat (8) begin
      @(negedge CLK);
      if (FrameStrobe != '0) cnt++;
    end
    chk("postrst_no_strobe", cnt, 0);

    // Randomized headers and data
    for (int k = 0; k < 40; k++) begin
      hdr = $urandom;
      if ($urandom_range(0, 9) < 8) hdr[31:24] = 8'hA5;
      else if (hdr[31:24] == 8'hA5) hdr[31:24] = 8'h5A;
      hdr[12:8] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hdr[4:0]  = 5'($urandom_range(0, 23));
      wv = {$urandom, $urandom, $urandom, $urandom};
      do_frame(hdr, wv, 2);
    end

    repeat (6) @(negedge CLK);
    chk("final_data", FrameData, exp_vec());
    chk("final_err_op", err_opcode, exp_err_op);
    chk("final_err_fr", err_frame, exp_err_fr);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hang anywhere in the flow.
  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_column_writer.md
Name: frame_column_writer

Overview:
- Configuration-side driver for one fabric column: consumes a stream of 32-bit configuration words, assembles one frame of FrameData covering every row, then pulses the matching one-hot FrameStrobe bit.
- Sits between the bitstream/config word source and the bottom of a column of tiles. It is the producer of the FrameData/FrameStrobe signals that tiles and terminal tiles buffer and pass upward.

Parameters:
- MaxFramesPerCol, 20, number of FrameStrobe lines per column.
- FrameBitsPerRow, 32, FrameData bits per row; equals the config word width.
- NumRows, 4, rows in the column; one data word per row per frame.
- ColIndex, 0, this column's address (0..31); headers with another column are skipped.
- StrobeWidth, 2, cycles FrameStrobe stays high per frame write (1..15).

Ports:
- CLK  in  1  configuration clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_data  in  32  configuration word.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  a word is accepted on a cycle when cfg_valid and cfg_ready are both high.
- FrameData  out  FrameBitsPerRow*NumRows  frame data; row k occupies bits [k*32 +: 32].
- FrameStrobe  out  MaxFramesPerCol  one-hot frame write strobe.
- busy  out  1  high in any state other than IDLE.
- err_opcode  out  1  sticky: a header had a bad opcode.
- err_frame  out  1  sticky: a header had a frame index ≥ MaxFramesPerCol.
- err_clr  in  1  synchronous clear of both error flags.

Behaviour:
- Reset (asynchronous, while resetn=0):
  - State=IDLE; row counter=0.
  - FrameData=0, FrameStrobe=0, error flags=0.
  - cfg_ready=1 once resetn=1 (in IDLE).
- Header format:
  - [31:24] opcode; 0xA5 means write-frame.
  - [12:8] column.
  - [4:0] frame index.
  - All other bits are ignored.
- IDLE, accepted header:
  - Opcode ≠ 0xA5: set err_opcode, drop the word, stay in IDLE. No data words are implied.
  - Opcode OK, frame index ≥ MaxFramesPerCol: set err_frame, go to SKIP.
  - Opcode OK, column ≠ ColIndex: go to SKIP (not an error).
  - Otherwise: latch the frame index, clear the row counter, go to LOAD.
- LOAD:
  - cfg_ready=1.
  - Each accepted word is written to FrameData row[row counter] on that clock edge; the row counter then increments.
  - After the word for row NumRows-1 is accepted, go to STROBE on the next edge.
  - Rows not yet rewritten keep their previous contents.
  - FrameStrobe=0 throughout LOAD.
- SKIP:
  - cfg_ready=1.
  - Accepts and discards exactly NumRows words; FrameData is unchanged.
  - Then returns to IDLE.
- STROBE:
  - cfg_ready=0.
  - FrameStrobe has exactly one bit high, the latched frame index, for exactly StrobeWidth cycles.
  - FrameData is held stable for the whole state.
- HOLD:
  - One cycle with cfg_ready=0 and FrameStrobe=0, giving data hold after the strobe falls.
  - Then returns to IDLE.
- Latency: from acceptance of the last data word, FrameStrobe rises on the 1st following clock edge, is high for StrobeWidth cycles, and cfg_ready returns 1 after StrobeWidth+1 cycles.
- FrameStrobe is registered. It is never multi-hot and never asserted outside STROBE.
- FrameData is registered. It changes only in LOAD and otherwise holds its last value indefinitely.
- cfg_valid low during LOAD/SKIP: the state machine stalls and no counters advance.
- Error flags:
  - Set and stay set until err_clr=1.
  - err_clr has priority over a same-cycle set: the flag reads 0 on the next cycle.
  - Error flags do not affect state flow.
- Reset during LOAD/STROBE: all outputs clear immediately, including a mid-pulse FrameStrobe. The partial frame is discarded and no strobe is issued after release.
- Row counter width is clog2(NumRows) with a minimum of 1; it never wraps past NumRows-1.

Test Plan:
- Header 0xA5000003, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → FrameData = 0x44444444_33333333_22222222_11111111; FrameStrobe = 0x00008 for 2 cycles starting 1 cycle after the 4th word; cfg_ready low 3 cycles.
- Header 0xA5000105 (column 1, ColIndex=0) plus 4 words → all 4 words accepted; FrameData unchanged; FrameStrobe stays 0; err flags 0.
- Header 0x3C000000 → err_opcode=1, stay IDLE. Next header 0xA5000014 (frame 20) → err_frame=1, 4 words skipped. Then err_clr → both flags 0.
- Valid header for frame 19, with cfg_valid toggled 1/0 every cycle during LOAD → all 4 words land in the correct rows; FrameStrobe = 0x80000 only after the 4th word.
- Back-to-back frames 0 then 1 with cfg_valid held high → strobes 0x00001 then 0x00002, never overlapping, separated by the HOLD cycle and the header cycle.
- resetn asserted in the 1st cycle of STROBE → FrameStrobe=0 and FrameData=0 immediately; after release, busy=0, cfg_ready=1, no strobe until a new complete frame.
